// File: rtl/axi_phase_sequencer.sv
// axi_phase_sequencer
// Steps the AXI4 test bench through its phases. Each phase is a write pass
// followed by a read pass. An optional byte-verification pass runs after the
// last phase. A watchdog aborts the run if any pass stalls.
module axi_phase_sequencer #(
  parameter int TOTAL_TEST_COUNT         = 64,
  parameter int PHASE_TEST_COUNT         = 8,
  parameter int BYTE_VERIFICATION_ENABLE = 1,
  parameter int TIMEOUT_CYCLES           = 100000,
  parameter int PHASE_W                  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               write_addr_phase_done,
  input  logic               write_data_phase_done,
  input  logic               read_addr_phase_done,
  input  logic               read_data_phase_done,
  input  logic               byte_verification_done_in,
  output logic               write_addr_phase_start,
  output logic               write_data_phase_start,
  output logic               read_addr_phase_start,
  output logic               read_data_phase_start,
  output logic               byte_verification_phase_start,
  output logic               byte_verification_phase_done,
  output logic [PHASE_W-1:0] current_phase,
  output logic               test_execution_completed,
  output logic               timeout_error,
  output logic               busy
);

  localparam int NUM_PHASES = TOTAL_TEST_COUNT / PHASE_TEST_COUNT;
  localparam bit HAS_PHASES = (NUM_PHASES > 0);
  localparam bit BV_EN      = (BYTE_VERIFICATION_ENABLE != 0);
  localparam bit WD_EN      = (TIMEOUT_CYCLES > 0);
  localparam logic [PHASE_W-1:0] LAST_PHASE =
    HAS_PHASES ? PHASE_W'(NUM_PHASES - 1) : '0;
  // Watchdog counter value at which the current pass is declared hung.
  localparam logic [31:0] WD_LIMIT =
    WD_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_BV,
    S_DONE,
    S_TIMEOUT
  } state_e;

  state_e             state_q;
  logic               wa_seen_q, wd_seen_q, ra_seen_q, rd_seen_q;
  logic               wa_seen_d, wd_seen_d, ra_seen_d, rd_seen_d;
  logic [31:0]        wdog_q;
  logic [PHASE_W-1:0] current_phase_q;
  logic               was_q, wds_q, ras_q, rds_q, bvs_q, bvd_q;
  logic               done_q, tmo_q, busy_q;
  logic               write_complete, read_complete, wdog_expired;

  // Merge this cycle's done pulses into the sticky flags of the active pass;
  // pulses belonging to the other pass leave its flags untouched.
  always_comb begin
    wa_seen_d = wa_seen_q;
    wd_seen_d = wd_seen_q;
    ra_seen_d = ra_seen_q;
    rd_seen_d = rd_seen_q;
    if (state_q == S_WRITE) begin
      wa_seen_d = wa_seen_q | write_addr_phase_done;
      wd_seen_d = wd_seen_q | write_data_phase_done;
    end
    if (state_q == S_READ) begin
      ra_seen_d = ra_seen_q | read_addr_phase_done;
      rd_seen_d = rd_seen_q | read_data_phase_done;
    end
    write_complete = wa_seen_d & wd_seen_d;
    read_complete  = ra_seen_d & rd_seen_d;
    wdog_expired   = WD_EN && (wdog_q == WD_LIMIT);
  end

  // Phase FSM with registered strobes, status outputs and pass watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      wa_seen_q       <= 1'b0;
      wd_seen_q       <= 1'b0;
      ra_seen_q       <= 1'b0;
      rd_seen_q       <= 1'b0;
      wdog_q          <= '0;
      current_phase_q <= '0;
      was_q           <= 1'b0;
      wds_q           <= 1'b0;
      ras_q           <= 1'b0;
      rds_q           <= 1'b0;
      bvs_q           <= 1'b0;
      bvd_q           <= 1'b0;
      done_q          <= 1'b0;
      tmo_q           <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      was_q <= 1'b0;
      wds_q <= 1'b0;
      ras_q <= 1'b0;
      rds_q <= 1'b0;
      bvs_q <= 1'b0;
      bvd_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            wdog_q <= '0;
            if (HAS_PHASES) begin
              state_q <= S_WRITE;
              was_q   <= 1'b1;
              wds_q   <= 1'b1;
              busy_q  <= 1'b1;
            end else if (BV_EN) begin
              state_q <= S_BV;
              bvs_q   <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (write_complete) begin
            wa_seen_q <= 1'b0;
            wd_seen_q <= 1'b0;
            wdog_q    <= '0;
            state_q   <= S_READ;
            ras_q     <= 1'b1;
            rds_q     <= 1'b1;
          end else if (wdog_expired) begin
            state_q <= S_TIMEOUT;
            tmo_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            wa_seen_q <= wa_seen_d;
            wd_seen_q <= wd_seen_d;
            if (WD_EN) wdog_q <= wdog_q + 32'd1;
          end
        end
        S_READ: begin
          if (read_complete) begin
            ra_seen_q <= 1'b0;
            rd_seen_q <= 1'b0;
            wdog_q    <= '0;
            if (current_phase_q < LAST_PHASE) begin
              current_phase_q <= current_phase_q + PHASE_W'(1);
              state_q         <= S_WRITE;
              was_q           <= 1'b1;
              wds_q           <= 1'b1;
            end else if (BV_EN) begin
              state_q <= S_BV;
              bvs_q   <= 1'b1;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end
          end else if (wdog_expired) begin
            state_q <= S_TIMEOUT;
            tmo_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            ra_seen_q <= ra_seen_d;
            rd_seen_q <= rd_seen_d;
            if (WD_EN) wdog_q <= wdog_q + 32'd1;
          end
        end
        S_BV: begin
          if (byte_verification_done_in) begin
            state_q <= S_DONE;
            bvd_q   <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else if (wdog_expired) begin
            state_q <= S_TIMEOUT;
            tmo_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else if (WD_EN) begin
            wdog_q <= wdog_q + 32'd1;
          end
        end
        S_DONE, S_TIMEOUT: begin
          state_q <= state_q;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign write_addr_phase_start        = was_q;
  assign write_data_phase_start        = wds_q;
  assign read_addr_phase_start         = ras_q;
  assign read_data_phase_start         = rds_q;
  assign byte_verification_phase_start = bvs_q;
  assign byte_verification_phase_done  = bvd_q;
  assign current_phase                 = current_phase_q;
  assign test_execution_completed      = done_q;
  assign timeout_error                 = tmo_q;
  assign busy                          = busy_q;

endmodule

// File: tb/tb_axi_phase_sequencer.sv
// Directed bench for axi_phase_sequencer. Three instances share the stimulus
// inputs; each has its own reset so only one is active at a time:
//   0: default parameters, 1: no byte verification with 2 phases,
//   2: 2 phases with a 20-cycle watchdog.
module tb_axi_phase_sequencer;

  logic clk = 1'b0;
  logic rst_n [3];
  logic start, wa_d, wd_d, ra_d, rd_d, bv_in;

  logic was [3];
  logic wds [3];
  logic ras [3];
  logic rds [3];
  logic bvs [3];
  logic bvd [3];
  logic tec [3];
  logic toe [3];
  logic bsy [3];
  logic [15:0] cph [3];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  axi_phase_sequencer dut0 (
    .clk(clk), .rst_n(rst_n[0]), .start(start),
    .write_addr_phase_done(wa_d), .write_data_phase_done(wd_d),
    .read_addr_phase_done(ra_d), .read_data_phase_done(rd_d),
    .byte_verification_done_in(bv_in),
    .write_addr_phase_start(was[0]), .write_data_phase_start(wds[0]),
    .read_addr_phase_start(ras[0]), .read_data_phase_start(rds[0]),
    .byte_verification_phase_start(bvs[0]), .byte_verification_phase_done(bvd[0]),
    .current_phase(cph[0]), .test_execution_completed(tec[0]),
    .timeout_error(toe[0]), .busy(bsy[0])
  );

  axi_phase_sequencer #(
    .TOTAL_TEST_COUNT(16), .PHASE_TEST_COUNT(8), .BYTE_VERIFICATION_ENABLE(0)
  ) dut1 (
    .clk(clk), .rst_n(rst_n[1]), .start(start),
    .write_addr_phase_done(wa_d), .write_data_phase_done(wd_d),
    .read_addr_phase_done(ra_d), .read_data_phase_done(rd_d),
    .byte_verification_done_in(bv_in),
    .write_addr_phase_start(was[1]), .write_data_phase_start(wds[1]),
    .read_addr_phase_start(ras[1]), .read_data_phase_start(rds[1]),
    .byte_verification_phase_start(bvs[1]), .byte_verification_phase_done(bvd[1]),
    .current_phase(cph[1]), .test_execution_completed(tec[1]),
    .timeout_error(toe[1]), .busy(bsy[1])
  );

  axi_phase_sequencer #(
    .TOTAL_TEST_COUNT(16), .PHASE_TEST_COUNT(8), .TIMEOUT_CYCLES(20)
  ) dut2 (
    .clk(clk), .rst_n(rst_n[2]), .start(start),
    .write_addr_phase_done(wa_d), .write_data_phase_done(wd_d),
    .read_addr_phase_done(ra_d), .read_data_phase_done(rd_d),
    .byte_verification_done_in(bv_in),
    .write_addr_phase_start(was[2]), .write_data_phase_start(wds[2]),
    .read_addr_phase_start(ras[2]), .read_data_phase_start(rds[2]),
    .byte_verification_phase_start(bvs[2]), .byte_verification_phase_done(bvd[2]),
    .current_phase(cph[2]), .test_execution_completed(tec[2]),
    .timeout_error(toe[2]), .busy(bsy[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
    else n_pass++;
  endtask

  // Output bits packed as {was,wds,ras,rds,bvs,bvd,tec,toe,busy}.
  function automatic logic [8:0] flags(input int d);
    return {was[d], wds[d], ras[d], rds[d], bvs[d], bvd[d], tec[d], toe[d], bsy[d]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Both write dones in the write strobe cycle, both read dones in the read strobe cycle.
  task automatic fast_phase();
    wa_d = 1; wd_d = 1; tick(); wa_d = 0; wd_d = 0;
    ra_d = 1; rd_d = 1; tick(); ra_d = 0; rd_d = 0;
  endtask

  initial begin
    rst_n[0] = 0; rst_n[1] = 0; rst_n[2] = 0;
    start = 0; wa_d = 0; wd_d = 0; ra_d = 0; rd_d = 0; bv_in = 0;
    tick(); tick();
    chk("reset flags", {23'd0, flags(0)}, 32'd0);
    chk("reset phase", {16'd0, cph[0]}, 32'd0);
    rst_n[0] = 1;
    tick();
    chk("idle no start", {23'd0, flags(0)}, 32'd0);

    // Full default run: drivers answer 3 cycles after each strobe, AW before W.
    start = 1; tick(); start = 0;
    for (int p = 0; p < 8; p++) begin
      chk($sformatf("A wr strobe p%0d", p), {23'd0, flags(0)}, 32'b1_1_0_0_0_0_0_0_1);
      chk($sformatf("A wr phase p%0d", p), {16'd0, cph[0]}, p);
      tick();
      chk($sformatf("A wr strobe width p%0d", p), {23'd0, flags(0)}, 32'b0_0_0_0_0_0_0_0_1);
      tick(); tick();
      wa_d = 1; tick(); wa_d = 0; wd_d = 1; tick(); wd_d = 0;
      chk($sformatf("A rd strobe p%0d", p), {23'd0, flags(0)}, 32'b0_0_1_1_0_0_0_0_1);
      chk($sformatf("A rd phase p%0d", p), {16'd0, cph[0]}, p);
      tick(); tick(); tick();
      ra_d = 1; tick(); ra_d = 0; rd_d = 1; tick(); rd_d = 0;
    end
    chk("A bv start", {23'd0, flags(0)}, 32'b0_0_0_0_1_0_0_0_1);
    chk("A final phase", {16'd0, cph[0]}, 32'd7);
    tick();
    chk("A bv wait", {23'd0, flags(0)}, 32'b0_0_0_0_0_0_0_0_1);
    tick();
    bv_in = 1; tick(); bv_in = 0;
    chk("A bv done+complete", {23'd0, flags(0)}, 32'b0_0_0_0_0_1_1_0_0);
    start = 1; tick(); start = 0;
    chk("A done sticky", {23'd0, flags(0)}, 32'b0_0_0_0_0_0_1_0_0);

    // Out-of-order write dones, then both read dones in the read strobe cycle.
    rst_n[0] = 0; tick(); rst_n[0] = 1; tick();
    start = 1; tick(); start = 0;
    chk("B wr strobe", {23'd0, flags(0)}, 32'b1_1_0_0_0_0_0_0_1);
    tick();
    wd_d = 1; tick(); wd_d = 0;
    chk("B wd only", {23'd0, flags(0)}, 32'b0_0_0_0_0_0_0_0_1);
    tick(); tick(); tick();
    wa_d = 1; tick(); wa_d = 0;
    chk("B rd strobe", {23'd0, flags(0)}, 32'b0_0_1_1_0_0_0_0_1);
    ra_d = 1; rd_d = 1; tick(); ra_d = 0; rd_d = 0;
    chk("B next wr strobe", {23'd0, flags(0)}, 32'b1_1_0_0_0_0_0_0_1);
    chk("B phase 1", {16'd0, cph[0]}, 32'd1);

    // Stray read-address done during WRITE must not be remembered.
    ra_d = 1; tick(); ra_d = 0;
    chk("F ra_seen stays 0", {31'd0, dut0.ra_seen_q}, 32'd0);
    wa_d = 1; wd_d = 1; tick(); wa_d = 0; wd_d = 0;
    chk("F rd strobe", {23'd0, flags(0)}, 32'b0_0_1_1_0_0_0_0_1);
    rd_d = 1; tick(); rd_d = 0;
    tick(); tick();
    chk("F read still waiting", {23'd0, flags(0)}, 32'b0_0_0_0_0_0_0_0_1);
    chk("F phase held", {16'd0, cph[0]}, 32'd1);
    ra_d = 1; tick(); ra_d = 0;
    chk("F wr strobe after ra", {23'd0, flags(0)}, 32'b1_1_0_0_0_0_0_0_1);
    chk("F phase 2", {16'd0, cph[0]}, 32'd2);

    // Asynchronous reset in the middle of phase 3.
    fast_phase();
    chk("E phase 3", {16'd0, cph[0]}, 32'd3);
    wa_d = 1; tick(); wa_d = 0;
    chk("E wa pending", {31'd0, dut0.wa_seen_q}, 32'd1);
    #2 rst_n[0] = 0;
    #1;
    chk("E async flags", {23'd0, flags(0)}, 32'd0);
    chk("E async phase", {16'd0, cph[0]}, 32'd0);
    chk("E flag lost", {31'd0, dut0.wa_seen_q}, 32'd0);
    tick(); rst_n[0] = 1; tick(); tick();
    chk("E no auto restart", {23'd0, flags(0)}, 32'd0);
    start = 1; tick(); start = 0;
    chk("E restart strobe", {23'd0, flags(0)}, 32'b1_1_0_0_0_0_0_0_1);
    chk("E restart phase", {16'd0, cph[0]}, 32'd0);

    // Two phases, no byte verification.
    rst_n[0] = 0; rst_n[1] = 1; tick();
    start = 1; tick(); start = 0;
    chk("C wr strobe p0", {23'd0, flags(1)}, 32'b1_1_0_0_0_0_0_0_1);
    fast_phase();
    chk("C wr strobe p1", {23'd0, flags(1)}, 32'b1_1_0_0_0_0_0_0_1);
    chk("C phase 1", {16'd0, cph[1]}, 32'd1);
    wa_d = 1; wd_d = 1; tick(); wa_d = 0; wd_d = 0;
    chk("C rd strobe p1", {23'd0, flags(1)}, 32'b0_0_1_1_0_0_0_0_1);
    ra_d = 1; rd_d = 1; tick(); ra_d = 0; rd_d = 0;
    chk("C complete", {23'd0, flags(1)}, 32'b0_0_0_0_0_0_1_0_0);
    chk("C phase held", {16'd0, cph[1]}, 32'd1);
    tick();
    chk("C no bv", {23'd0, flags(1)}, 32'b0_0_0_0_0_0_1_0_0);

    // Watchdog of 20 cycles with the read-data done withheld.
    rst_n[1] = 0; rst_n[2] = 1; tick();
    start = 1; tick(); start = 0;
    chk("D wr strobe", {23'd0, flags(2)}, 32'b1_1_0_0_0_0_0_0_1);
    wa_d = 1; wd_d = 1; tick(); wa_d = 0; wd_d = 0;
    chk("D rd strobe", {23'd0, flags(2)}, 32'b0_0_1_1_0_0_0_0_1);
    ra_d = 1; tick(); ra_d = 0;
    repeat (8) tick();
    chk("D still busy", {23'd0, flags(2)}, 32'b0_0_0_0_0_0_0_0_1);
    repeat (15) tick();
    chk("D timed out", {23'd0, flags(2)}, 32'b0_0_0_0_0_0_0_1_0);
    wa_d = 1; wd_d = 1; ra_d = 1; rd_d = 1; bv_in = 1; start = 1;
    tick();
    wa_d = 0; wd_d = 0; ra_d = 0; rd_d = 0; bv_in = 0; start = 0;
    chk("D late dones ignored", {23'd0, flags(2)}, 32'b0_0_0_0_0_0_0_1_0);
    tick();
    chk("D timeout sticky", {23'd0, flags(2)}, 32'b0_0_0_0_0_0_0_1_0);
    chk("D phase", {16'd0, cph[2]}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
